// File: rtl/feeder_pkg.sv
// Shared types and default sizing for the systolic feeder.
package feeder_pkg;

  typedef enum logic {
    StIdle,
    StStream
  } feeder_state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 7;
  localparam int unsigned DefLanes = 4;

endpackage

// File: rtl/feeder_lane.sv
// One feeder lane: MSB-first element shift register whose output is gated to the
// step window [OFFSET, OFFSET+DEPTH).
module feeder_lane
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned OFFSET = 0,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic                    i_idle,
  input  logic                    i_step,
  input  logic [CNT_W-1:0]        i_step_cnt,
  input  logic [DEPTH*DATA_W-1:0] i_data,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid
);

  localparam int unsigned        SrW = DEPTH * DATA_W;
  localparam logic [CNT_W-1:0]   WinLo = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0]   WinHi = CNT_W'(OFFSET + DEPTH);

  logic [SrW-1:0] r_shreg;
  logic           w_in_range;

  // A zero offset needs only the upper bound; no lower comparator is built.
  if (OFFSET == 0) begin : g_no_off
    assign w_in_range = (i_step_cnt < WinHi);
  end else begin : g_off
    assign w_in_range = (i_step_cnt >= WinLo) && (i_step_cnt < WinHi);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_shreg <= i_data;
      end
      if (i_idle) begin
        o_data  <= '0;
        o_valid <= 1'b0;
      end else if (i_step) begin
        if (w_in_range) begin
          o_data  <= r_shreg[SrW-1 -: DATA_W];
          o_valid <= 1'b1;
          r_shreg <= r_shreg << DATA_W;
        end else begin
          o_data  <= '0;
          o_valid <= 1'b0;
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Burst loader and stepper feeding LANES rows of a systolic array.
// Define FEEDER_SKEW_EN to offset lane l by l steps (diagonal wavefront).
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned LANES  = DefLanes
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [LANES*DEPTH*DATA_W-1:0] load_data,
  input  logic                          enable,
  output logic [LANES*DATA_W-1:0]       data_out,
  output logic [LANES-1:0]              out_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CntW = $clog2(DEPTH + LANES);
`ifdef FEEDER_SKEW_EN
  localparam int unsigned Skew = LANES - 1;
`else
  localparam int unsigned Skew = 0;
`endif
  localparam int unsigned      Steps = DEPTH + Skew;
  localparam logic [CntW-1:0]  LastStep = CntW'(Steps - 1);
  localparam int unsigned      LaneW = DEPTH * DATA_W;

  feeder_state_e   r_state;
  logic [CntW-1:0] r_step;
  logic            r_done;
  logic            w_accept;
  logic            w_idle;
  logic            w_step;

  assign w_idle     = (r_state == StIdle);
  assign w_accept   = w_idle && load_valid;
  assign w_step     = (r_state == StStream) && enable;
  assign load_ready = w_idle;
  assign busy       = (r_state == StStream);
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (load_valid) begin
            r_state <= StStream;
            r_step  <= '0;
          end
        end
        StStream: begin
          if (enable) begin
            if (r_step == LastStep) begin
              r_state <= StIdle;
              r_step  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_step <= r_step + CntW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef FEEDER_SKEW_EN
    localparam int unsigned LaneOff = l;
`else
    localparam int unsigned LaneOff = 0;
`endif
    feeder_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .OFFSET (LaneOff),
      .CNT_W  (CntW)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept),
      .i_idle     (w_idle),
      .i_step     (w_step),
      .i_step_cnt (r_step),
      .i_data     (load_data[(l+1)*LaneW-1 -: LaneW]),
      .o_data     (data_out[l*DATA_W +: DATA_W]),
      .o_valid    (out_valid[l])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (LANES=4, DEPTH=7, DATA_W=8); follows FEEDER_SKEW_EN.
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int DP = 7;
  localparam int LN = 4;
`ifdef FEEDER_SKEW_EN
  localparam int T = DP + LN - 1;
`else
  localparam int T = DP;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                load_valid;
  logic                load_ready;
  logic [LN*DP*DW-1:0] load_data;
  logic                enable;
  logic [LN*DW-1:0]    data_out;
  logic [LN-1:0]       out_valid;
  logic                busy;
  logic                done;

  int checks = 0;
  int failures = 0;

  logic [LN*DP*DW-1:0] burst_a;
  logic [LN*DP*DW-1:0] burst_b;
  logic [LN*DP*DW-1:0] all_ff;
  logic [35:0]         exp_v;
  logic [31:0]         prev_data;

  systolic_feeder #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .LANES  (LN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .enable     (enable),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected {out_valid, data_out} after the enable issuing step s.
  function automatic logic [35:0] model(input logic [LN*DP*DW-1:0] b, input int s);
    logic [31:0] d;
    logic [3:0]  v;
    int          k;
    d = '0;
    v = '0;
    for (int l = 0; l < LN; l++) begin
`ifdef FEEDER_SKEW_EN
      k = s - l;
`else
      k = s;
`endif
      if (k >= 0 && k < DP) begin
        d[l*DW +: DW] = b[(l*DP + DP - 1 - k)*DW +: DW];
        v[l] = 1'b1;
      end
    end
    return {v, d};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_data"}, 64'(data_out), 64'h0);
    chk({tag, "_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_ready"}, 64'(load_ready), 64'h1);
  endtask

  task automatic load(input logic [LN*DP*DW-1:0] b);
    load_data  = b;
    load_valid = 1'b1;
    enable     = 1'b0;
    tick();
    load_valid = 1'b0;
    chk("load_busy", 64'(busy), 64'h1);
    chk("load_ready_low", 64'(load_ready), 64'h0);
    chk("load_no_valid", 64'(out_valid), 64'h0);
  endtask

  task automatic run_stream(input logic [LN*DP*DW-1:0] b);
    logic [35:0] e;
    load(b);
    enable = 1'b1;
    for (int s = 0; s < T; s++) begin
      tick();
      e = model(b, s);
      chk("run_data", 64'(data_out), 64'(e[31:0]));
      chk("run_valid", 64'(out_valid), 64'(e[35:32]));
      chk("run_done", 64'(done), 64'(s == T - 1));
      chk("run_ready", 64'(load_ready), 64'(s == T - 1));
    end
    enable = 1'b0;
    tick();
    chk("run_done_clear", 64'(done), 64'h0);
    check_idle("run_after");
  endtask

  initial begin
    burst_a = {56'h0, 56'h0, 56'hA1B2C3D4E5F607, 56'h11223344556677};
    burst_b = {56'hF0E0D0C0B0A090, 56'h01020304050607, 56'h89ABCDEF012345, 56'h5A5B5C5D5E5F50};
    all_ff  = '1;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    enable     = 1'b0;
    tick();
    tick();
    check_idle("reset");
    chk("reset_done", 64'(done), 64'h0);
    reset = 1'b0;

    // Enable in IDLE must be ignored.
    enable = 1'b1;
    tick();
    check_idle("idle_enable");

    // Continuous stream of burst A with hand-derived spot checks.
    load(burst_a);
    enable = 1'b1;
    for (int c = 1; c <= T; c++) begin
      tick();
      exp_v = model(burst_a, c - 1);
      chk("cont_data", 64'(data_out), 64'(exp_v[31:0]));
      chk("cont_valid", 64'(out_valid), 64'(exp_v[35:32]));
      chk("cont_done", 64'(done), 64'(c == T));
      if (c == 1) chk("cont_lane0_first", 64'(data_out[7:0]), 64'h11);
      if (c == 7) chk("cont_lane0_last", 64'(data_out[7:0]), 64'h77);
`ifdef FEEDER_SKEW_EN
      if (c == 2) chk("cont_lane1_first", 64'(data_out[15:8]), 64'hA1);
      if (c == 3) chk("cont_v3_pre", 64'(out_valid[3]), 64'h0);
      if (c == 4) chk("cont_v3_first", 64'(out_valid[3]), 64'h1);
      if (c == 8) chk("cont_lane1_last", 64'(data_out[15:8]), 64'h07);
`else
      if (c == 1) chk("cont_lane1_first", 64'(data_out[15:8]), 64'hA1);
      if (c == 1) chk("cont_all_valid", 64'(out_valid), 64'hF);
`endif
    end
    enable = 1'b0;
    tick();
    check_idle("cont_after");

    // Every-other-cycle enable, with an all-ones burst offered during STREAM.
    load(burst_a);
    prev_data = '0;
    for (int i = 0; i < T; i++) begin
      enable     = 1'b1;
      load_valid = 1'b1;
      load_data  = all_ff;
      tick();
      exp_v = model(burst_a, i);
      chk("gap_step_data", 64'(data_out), 64'(exp_v[31:0]));
      chk("gap_step_valid", 64'(out_valid), 64'(exp_v[35:32]));
      chk("gap_step_done", 64'(done), 64'(i == T - 1));
      enable = 1'b0;
      if (i == T - 1) load_valid = 1'b0;
      else chk("gap_ready_low", 64'(load_ready), 64'h0);
      tick();
      chk("gap_hold_valid", 64'(out_valid), 64'h0);
      chk("gap_hold_done", 64'(done), 64'h0);
      if (i < T - 1) chk("gap_hold_data", 64'(data_out), 64'(exp_v[31:0]));
      else check_idle("gap_after");
    end
    load_valid = 1'b0;

    // Reset after the third enable, then restream the burst from element 0.
    load(burst_b);
    enable = 1'b1;
    tick();
    tick();
    tick();
    exp_v = model(burst_b, 2);
    chk("mid_step2_data", 64'(data_out), 64'(exp_v[31:0]));
    reset      = 1'b1;
    load_valid = 1'b1;
    tick();
    chk("mid_reset_done", 64'(done), 64'h0);
    check_idle("mid_reset");
    reset      = 1'b0;
    load_valid = 1'b0;
    enable     = 1'b0;
    tick();
    check_idle("post_reset");
    run_stream(burst_b);

    // A new burst is accepted in the done cycle itself.
    load(burst_b);
    enable = 1'b1;
    for (int s = 0; s < T; s++) tick();
    chk("done_pulse", 64'(done), 64'h1);
    enable     = 1'b0;
    load_valid = 1'b1;
    load_data  = burst_a;
    tick();
    load_valid = 1'b0;
    chk("done_accept_busy", 64'(busy), 64'h1);
    chk("done_accept_data", 64'(data_out), 64'h0);
    enable = 1'b1;
    tick();
    exp_v = model(burst_a, 0);
    chk("done_accept_step0", 64'(data_out), 64'(exp_v[31:0]));
    chk("done_accept_valid0", 64'(out_valid), 64'(exp_v[35:32]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
